// File: rtl/flood_pkg.sv
// Shared types and constants for the Flood-It game controller and its helpers.
package flood_pkg;

    localparam int COLOR_W    = 3;
    localparam int SEED_W     = 16;
    localparam int MOVE_W     = 6;
    localparam int MIN_COLORS = 3;
    localparam int MAX_COLORS = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_GEN_REQ = 3'd1,
        ST_GEN_REL = 3'd2,
        ST_PLAY    = 3'd3,
        ST_FLOOD   = 3'd4,
        ST_WIN     = 3'd5,
        ST_LOSE    = 3'd6
    } state_t;

    // Product is formed in 8 bits; 26*8=208 so the quarter plus 4 stays within 56.
    function automatic logic [MOVE_W-1:0] calc_move_limit(input logic [4:0] size,
                                                           input logic [3:0] colors);
        logic [7:0] prod;
        prod = 8'(size) * 8'(colors);
        return MOVE_W'(prod >> 2) + MOVE_W'(4);
    endfunction

endpackage

// File: rtl/game_sequencer_param_clamp.sv
// Combinational clamp of requested board size / colour count and derived move limit.
// Shared with the status display so both always agree on the effective game setup.
module param_clamp
    import flood_pkg::*;
#(
    parameter int MAX_SIZE = 26,
    parameter int MIN_SIZE = 2
) (
    input  logic [4:0]        size_sel,
    input  logic [3:0]        color_sel,
    output logic [4:0]        size,
    output logic [3:0]        color_num,
    output logic [MOVE_W-1:0] move_limit
);

    always_comb begin
        size = size_sel;
        if (size_sel < 5'(MIN_SIZE))
            size = 5'(MIN_SIZE);
        else if (size_sel > 5'(MAX_SIZE))
            size = 5'(MAX_SIZE);
    end

    always_comb begin
        color_num = color_sel;
        if (color_sel < 4'(MIN_COLORS))
            color_num = 4'(MIN_COLORS);
        else if (color_sel > 4'(MAX_COLORS))
            color_num = 4'(MAX_COLORS);
    end

    assign move_limit = calc_move_limit(size, color_num);

endmodule

// File: rtl/game_sequencer.sv
// Flood-It game controller: generator handshake, pick filtering, flood launch, move count, win/lose.
// Optional AUTO_SEED_EN substitutes a free-running counter when SEED_IN is zero at START.
module game_sequencer
    import flood_pkg::*;
#(
    parameter int MAX_SIZE = 26,
    parameter int MIN_SIZE = 2
) (
    input  logic                CLOCK,
    input  logic                RESET,
    input  logic                START,
    input  logic [SEED_W-1:0]   SEED_IN,
    input  logic [4:0]          SIZE_SEL,
    input  logic [3:0]          COLOR_SEL,
    output logic                GEN_NEW_BOARD,
    output logic [SEED_W-1:0]   GEN_SEED,
    output logic [4:0]          GEN_SIZE,
    output logic [3:0]          GEN_COLOR_NUM,
    input  logic                GEN_READY,
    input  logic [COLOR_W-1:0]  CORNER_COLOR,
    input  logic                PICK_VALID,
    input  logic [COLOR_W-1:0]  PICK_COLOR,
    output logic                FLOOD_START,
    output logic [COLOR_W-1:0]  FLOOD_COLOR,
    input  logic                FLOOD_DONE,
    input  logic                FLOOD_FILLED,
    output logic [MOVE_W-1:0]   MOVES,
    output logic [MOVE_W-1:0]   MOVE_LIMIT,
    output logic [2:0]          STATE,
    output logic                WIN,
    output logic                LOSE
);

    state_t              state;
    logic                new_board_q;
    logic                pending;
    logic                restart;
    logic                start_go;
    logic                pick_ok;
    logic [4:0]          clamp_size;
    logic [3:0]          clamp_colors;
    logic [MOVE_W-1:0]   clamp_limit;
    logic [SEED_W-1:0]   seed_pick;

    param_clamp #(
        .MAX_SIZE (MAX_SIZE),
        .MIN_SIZE (MIN_SIZE)
    ) u_clamp (
        .size_sel   (SIZE_SEL),
        .color_sel  (COLOR_SEL),
        .size       (clamp_size),
        .color_num  (clamp_colors),
        .move_limit (clamp_limit)
    );

`ifdef AUTO_SEED_EN
    logic [SEED_W-1:0] seed_ctr;

    always_ff @(posedge CLOCK) begin
        if (RESET)
            seed_ctr <= 16'h0001;
        else if (seed_ctr == 16'hFFFF)
            seed_ctr <= 16'h0001;
        else
            seed_ctr <= seed_ctr + 16'h0001;
    end

    assign seed_pick = (SEED_IN == '0) ? seed_ctr : SEED_IN;
`else
    assign seed_pick = SEED_IN;
`endif

    // A deferred START from FLOOD is replayed through the same path as a direct one.
    always_comb begin
        start_go = restart;
        if (START && (state == ST_IDLE || state == ST_PLAY ||
                      state == ST_WIN  || state == ST_LOSE))
            start_go = 1'b1;
    end

    assign pick_ok = PICK_VALID && ({1'b0, PICK_COLOR} < GEN_COLOR_NUM) &&
                     (PICK_COLOR != CORNER_COLOR);

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state         <= ST_IDLE;
            new_board_q   <= 1'b0;
            pending       <= 1'b0;
            restart       <= 1'b0;
            GEN_SEED      <= '0;
            GEN_SIZE      <= '0;
            GEN_COLOR_NUM <= '0;
            FLOOD_START   <= 1'b0;
            FLOOD_COLOR   <= '0;
            MOVES         <= '0;
            MOVE_LIMIT    <= '0;
            WIN           <= 1'b0;
            LOSE          <= 1'b0;
        end else begin
            FLOOD_START <= 1'b0;
            if (start_go) begin
                GEN_SEED      <= seed_pick;
                GEN_SIZE      <= clamp_size;
                GEN_COLOR_NUM <= clamp_colors;
                MOVE_LIMIT    <= clamp_limit;
                MOVES         <= '0;
                WIN           <= 1'b0;
                LOSE          <= 1'b0;
                pending       <= 1'b0;
                restart       <= 1'b0;
                new_board_q   <= 1'b1;
                state         <= ST_GEN_REQ;
            end else begin
                case (state)
                    ST_GEN_REQ: begin
                        if (GEN_READY) begin
                            new_board_q <= 1'b0;
                            state       <= ST_GEN_REL;
                        end
                    end
                    ST_GEN_REL: begin
                        if (!GEN_READY)
                            state <= ST_PLAY;
                    end
                    ST_PLAY: begin
                        if (pick_ok) begin
                            FLOOD_COLOR <= PICK_COLOR;
                            FLOOD_START <= 1'b1;
                            state       <= ST_FLOOD;
                        end
                    end
                    ST_FLOOD: begin
                        if (START)
                            pending <= 1'b1;
                        if (FLOOD_DONE) begin
                            MOVES <= MOVES + 1'b1;
                            // Let the counted move show for a cycle before a queued restart.
                            if (pending || START)
                                restart <= 1'b1;
                            else if (FLOOD_FILLED) begin
                                WIN   <= 1'b1;
                                state <= ST_WIN;
                            end else if (MOVES + 1'b1 == MOVE_LIMIT) begin
                                LOSE  <= 1'b1;
                                state <= ST_LOSE;
                            end else
                                state <= ST_PLAY;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Gated by RESET so a reset mid-generation withdraws the request immediately.
    assign GEN_NEW_BOARD = new_board_q & ~RESET;
    assign STATE         = state;

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level game controller for Flood-It.
- Sequences the board generator through its NEW_BOARD/READY handshake, then accepts player colour picks and hands each one to the flood-fill engine.
- Counts moves against a limit derived from board size and colour count, and declares WIN or LOSE.
- Sits between the debounced button/switch logic and the generate_board and flood-fill datapaths.

Parameters:
- MAX_SIZE, 26, largest legal board edge; matches the 26x26 board array.
- MIN_SIZE, 2, smallest legal board edge.

Ports:
- CLOCK  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- START  in  1  one-cycle pulse: begin a new game
- SEED_IN  in  16  seed forwarded to the generator
- SIZE_SEL  in  5  requested board edge
- COLOR_SEL  in  4  requested colour count
- GEN_NEW_BOARD  out  1  generator request (level)
- GEN_SEED  out  16  seed to the generator
- GEN_SIZE  out  5  clamped size to the generator
- GEN_COLOR_NUM  out  4  clamped colour count to the generator
- GEN_READY  in  1  generator done
- CORNER_COLOR  in  3  current colour of cell [0][0]
- PICK_VALID  in  1  one-cycle pick strobe
- PICK_COLOR  in  3  picked colour
- FLOOD_START  out  1  one-cycle flood launch
- FLOOD_COLOR  out  3  colour to flood with
- FLOOD_DONE  in  1  flood engine finished (pulse)
- FLOOD_FILLED  in  1  board is uniform; valid with FLOOD_DONE
- MOVES  out  6  moves used
- MOVE_LIMIT  out  6  moves allowed
- STATE  out  3  FSM state encoding
- WIN  out  1  game won (level)
- LOSE  out  1  game lost (level)

Behaviour:
- Reset values: all outputs 0, including GEN_SEED, GEN_SIZE and GEN_COLOR_NUM. FSM goes to IDLE.
- FSM states and encoding: IDLE=0, GEN_REQ=1, GEN_REL=2, PLAY=3, FLOOD=4, WIN=5, LOSE=6.
- START, sampled in IDLE, PLAY, WIN or LOSE:
  - Latch GEN_SEED=SEED_IN.
  - Latch GEN_SIZE=clamp(SIZE_SEL, MIN_SIZE, MAX_SIZE).
  - Latch GEN_COLOR_NUM=clamp(COLOR_SEL, 3, 8).
  - Set MOVE_LIMIT=((GEN_SIZE*GEN_COLOR_NUM)>>2)+4. Compute the product in 8 bits; the result always fits in 6 bits (max 56).
  - Clear MOVES, WIN and LOSE; go to GEN_REQ.
- GEN_REQ:
  - GEN_NEW_BOARD=1.
  - When GEN_READY=1: drop GEN_NEW_BOARD next cycle and go to GEN_REL.
- GEN_REL:
  - GEN_NEW_BOARD=0; wait for GEN_READY=0, then go to PLAY.
  - This is the generator's ready-release handshake: READY must clear before any new request.
- START in GEN_REQ/GEN_REL: ignored. The generator cannot be aborted mid-run.
- PLAY, on PICK_VALID:
  - Reject with no state change if PICK_COLOR >= GEN_COLOR_NUM or PICK_COLOR == CORNER_COLOR. A rejected pick is not counted.
  - Otherwise latch FLOOD_COLOR=PICK_COLOR, pulse FLOOD_START for exactly 1 cycle (the cycle after the pick), and go to FLOOD.
- FLOOD:
  - PICK_VALID is ignored.
  - On FLOOD_DONE, MOVES increments, then:
    - FLOOD_FILLED=1: go to WIN. WIN has priority even when MOVES reaches MOVE_LIMIT on the same move.
    - else MOVES+1 == MOVE_LIMIT: go to LOSE.
    - else: go to PLAY.
- START arriving in FLOOD:
  - Set a pending flag; do not abort the flood engine.
  - On FLOOD_DONE, the move is counted as normal. Then, instead of the win/lose/play transition, apply the START action using the latched pending request with the current SEED_IN/SIZE_SEL/COLOR_SEL.
  - Clear the pending flag.
- WIN/LOSE: outputs held; only START or RESET leaves.
- RESET mid-generation drops GEN_NEW_BOARD the same cycle. The generator then sees NEW_BOARD low and clears READY on its own.
- FLOOD_DONE outside FLOOD and GEN_READY outside GEN_REQ/GEN_REL are ignored.

Optional Feature:
- Macro: AUTO_SEED_EN.
- Defined:
  - A free-running 16-bit counter starts at 16'h0001 on reset and increments every cycle, skipping 0.
  - When SEED_IN==0 at START, GEN_SEED takes the counter value instead, so consecutive games differ.
- Undefined: GEN_SEED=SEED_IN unconditionally; SEED_IN==0 is passed through and the generator substitutes its default seed.

Decomposition:
- Package flood_pkg holds:
  - the state enum/localparams;
  - MIN_COLORS=3, MAX_COLORS=8;
  - widths COLOR_W=3, SEED_W=16, MOVE_W=6;
  - a function computing the move limit.
- One natural sub-module, param_clamp: combinational clamping of size/colours plus limit computation, reused by the VGA status display.

Test Plan:
- RESET, then START with SIZE_SEL=14, COLOR_SEL=6 -> GEN_SIZE=14, GEN_COLOR_NUM=6, MOVE_LIMIT=25, GEN_NEW_BOARD=1 the next cycle.
- Generator model raises GEN_READY after 400 cycles and holds it until NEW_BOARD drops -> GEN_NEW_BOARD falls 1 cycle after READY; STATE=PLAY only after READY falls.
- In PLAY with CORNER_COLOR=2 and GEN_COLOR_NUM=4, picks of 2 and 5 -> no FLOOD_START, MOVES=0; pick 3 -> FLOOD_START single pulse, FLOOD_COLOR=3.
- SIZE_SEL=31, COLOR_SEL=1 -> clamped to 26 and 3, MOVE_LIMIT=23; drive 23 non-filling floods -> LOSE=1, MOVES=23; START -> LOSE=0, MOVES=0.
- On the 23rd move, FLOOD_DONE arrives with FLOOD_FILLED=1 -> WIN=1, LOSE=0.
- START mid-FLOOD, then FLOOD_DONE -> MOVES increments, then STATE=GEN_REQ with MOVES cleared. With AUTO_SEED_EN and SEED_IN=0 -> GEN_SEED is nonzero and differs across two starts.
